// File: rtl/stack_seq_pkg.sv
// Shared types for the stack sequencer: command ops, FSM states,
// vector selects, status bit positions and small decode helpers.
package stack_seq_pkg;

    typedef enum logic [2:0] {
        OP_PHA = 3'd0,
        OP_PHP = 3'd1,
        OP_PLA = 3'd2,
        OP_PLP = 3'd3,
        OP_JSR = 3'd4,
        OP_RTS = 3'd5,
        OP_INT = 3'd6,
        OP_RTI = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_VREQ  = 3'd3,
        S_VWAIT = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [1:0] VEC_NMI = 2'd0;
    localparam logic [1:0] VEC_RST = 2'd1;
    localparam logic [1:0] VEC_IRQ = 2'd2;
    localparam logic [1:0] VEC_BRK = 2'd3;

    localparam int P_I = 2;
    localparam int P_B = 4;
    localparam int P_U = 5;

    // Index of the last stack byte for an op (byte count - 1).
    function automatic logic [1:0] op_last(input op_e op);
        logic [1:0] r;
        r = 2'd0;
        unique case (op)
            OP_JSR, OP_RTS: r = 2'd1;
            OP_INT, OP_RTI: r = 2'd2;
            default:        r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_push(input op_e op);
        return (op == OP_PHA) || (op == OP_PHP) ||
               (op == OP_JSR) || (op == OP_INT);
    endfunction

    // A status byte pulled off the stack always reads U=1, B=0.
    function automatic logic [7:0] fix_pop_p(input logic [7:0] b);
        logic [7:0] r;
        r      = b;
        r[P_U] = 1'b1;
        r[P_B] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/stack_sequencer.sv
// Stack sequencer: expands one stack-class op into byte push/pop strobes,
// fetches the interrupt vector, and returns PC/P/A with load pulses.
// Ports: cmd_* handshake in, stack_* strobes/data to the memory
// controller, vec_* vector read port, *_out/*_load/done results, busy.
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] RST_VEC = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [1:0]  cmd_vec,
    input  logic        cmd_brk,
    input  logic [15:0] pc_in,
    input  logic [7:0]  p_in,
    input  logic [7:0]  a_in,
    output logic        stack_push,
    output logic        stack_pop,
    output logic [7:0]  stack_data_out,
    input  logic [7:0]  stack_data_in,
    input  logic        mem_ready,
    output logic        vec_read,
    output logic [15:0] vec_addr,
    input  logic [7:0]  vec_data,
    output logic [15:0] pc_out,
    output logic [7:0]  p_out,
    output logic [7:0]  a_out,
    output logic        pc_load,
    output logic        p_load,
    output logic        a_load,
    output logic        done,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    op_e         op_q;
    logic [1:0]  vec_q;
    logic        brk_q;
    logic [15:0] pc_q;
    logic [7:0]  p_q;
    logic [7:0]  a_q;
    logic [7:0]  b0_q, b1_q;
    logic [15:0] pc_out_q, pc_out_d;
    logic [7:0]  p_out_q, p_out_d;
    logic [7:0]  a_out_q, a_out_d;

    logic        accept;
    logic        last;
    logic        is_push;
    logic [7:0]  push_byte;
    logic [15:0] vec_base;

    assign accept  = cmd_valid && (state_q == S_IDLE);
    assign last    = (idx_q == op_last(op_q));
    assign is_push = op_is_push(op_q);

    // Byte to push for the current op and byte index.
    always_comb begin
        push_byte = 8'h00;
        unique case (op_q)
            OP_PHA: push_byte = a_q;
            OP_PHP: push_byte = p_q | 8'h30;
            OP_JSR: push_byte = (idx_q == 2'd0) ? pc_q[15:8] : pc_q[7:0];
            OP_INT: begin
                unique case (idx_q)
                    2'd0:    push_byte = pc_q[15:8];
                    2'd1:    push_byte = pc_q[7:0];
                    default: push_byte = {p_q[7:6], 1'b1, brk_q, p_q[3:0]};
                endcase
            end
            default: push_byte = 8'h00;
        endcase
    end

    always_comb begin
        vec_base = IRQ_VEC;
        unique case (vec_q)
            VEC_NMI: vec_base = NMI_VEC;
            VEC_RST: vec_base = RST_VEC;
            default: vec_base = IRQ_VEC;
        endcase
    end

    // Next state and strobe/pulse outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cmd_ready  = 1'b0;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        vec_read   = 1'b0;
        done       = 1'b0;
        pc_load    = 1'b0;
        p_load     = 1'b0;
        a_load     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    idx_d   = 2'd0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                stack_push = is_push;
                stack_pop  = !is_push;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ready) begin
                    if (!last) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_REQ;
                    end else if (op_q == OP_INT) begin
                        idx_d   = 2'd0;
                        state_d = S_VREQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_VREQ: begin
                vec_read = 1'b1;
                state_d  = S_VWAIT;
            end
            S_VWAIT: begin
                if (mem_ready) begin
                    if (idx_q == 2'd0) begin
                        idx_d   = 2'd1;
                        state_d = S_VREQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                pc_load = (op_q == OP_RTS) || (op_q == OP_RTI) ||
                          (op_q == OP_INT);
                p_load  = (op_q == OP_PLP) || (op_q == OP_RTI) ||
                          (op_q == OP_INT);
                a_load  = (op_q == OP_PLA);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Results are settled on the transition into DONE so they are
    // stable while the load pulses are high.
    always_comb begin
        pc_out_d = pc_out_q;
        p_out_d  = p_out_q;
        a_out_d  = a_out_q;
        if (state_q == S_WAIT && mem_ready && last) begin
            unique case (op_q)
                OP_PLA: a_out_d  = stack_data_in;
                OP_PLP: p_out_d  = fix_pop_p(stack_data_in);
                OP_RTS: pc_out_d = {stack_data_in, b0_q} + 16'd1;
                OP_RTI: begin
                    p_out_d  = fix_pop_p(b0_q);
                    pc_out_d = {stack_data_in, b1_q};
                end
                default: ;
            endcase
        end
        if (state_q == S_VWAIT && mem_ready) begin
            if (idx_q == 2'd0) begin
                pc_out_d[7:0] = vec_data;
            end else begin
                pc_out_d[15:8] = vec_data;
                p_out_d        = p_q;
                p_out_d[P_I]   = 1'b1;
            end
        end
    end

    assign stack_data_out = stack_push ? push_byte : 8'h00;
    assign vec_addr       = vec_read ? (vec_base + {15'd0, idx_q[0]})
                                     : 16'h0000;
    assign busy           = (state_q != S_IDLE);
    assign pc_out         = pc_out_q;
    assign p_out          = p_out_q;
    assign a_out          = a_out_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            op_q     <= OP_PHA;
            vec_q    <= 2'd0;
            brk_q    <= 1'b0;
            pc_q     <= 16'h0000;
            p_q      <= 8'h00;
            a_q      <= 8'h00;
            b0_q     <= 8'h00;
            b1_q     <= 8'h00;
            pc_out_q <= 16'h0000;
            p_out_q  <= 8'h20;
            a_out_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pc_out_q <= pc_out_d;
            p_out_q  <= p_out_d;
            a_out_q  <= a_out_d;
            if (accept) begin
                op_q  <= op_e'(cmd_op);
                vec_q <= cmd_vec;
                brk_q <= cmd_brk;
                pc_q  <= pc_in;
                p_q   <= p_in;
                a_q   <= a_in;
            end
            if (state_q == S_WAIT && mem_ready && !is_push) begin
                if (idx_q == 2'd0) b0_q <= stack_data_in;
                if (idx_q == 2'd1) b1_q <= stack_data_in;
            end
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: directed commands queue the
// expected strobes and results; a monitor compares them as they appear.
module tb_stack_sequencer;

    typedef struct {
        int          lat;
        logic        pcl;
        logic        pl;
        logic        al;
        logic [15:0] pc;
        logic [7:0]  p;
        logic [7:0]  a;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_vec;
    logic        cmd_brk;
    logic [15:0] pc_in;
    logic [7:0]  p_in;
    logic [7:0]  a_in;
    logic        stack_push;
    logic        stack_pop;
    logic [7:0]  stack_data_out;
    logic [7:0]  stack_data_in;
    logic        mem_ready;
    logic        vec_read;
    logic [15:0] vec_addr;
    logic [7:0]  vec_data;
    logic [15:0] pc_out;
    logic [7:0]  p_out;
    logic [7:0]  a_out;
    logic        pc_load;
    logic        p_load;
    logic        a_load;
    logic        done;
    logic        busy;

    stack_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_vec(cmd_vec), .cmd_brk(cmd_brk),
        .pc_in(pc_in), .p_in(p_in), .a_in(a_in),
        .stack_push(stack_push), .stack_pop(stack_pop),
        .stack_data_out(stack_data_out), .stack_data_in(stack_data_in),
        .mem_ready(mem_ready),
        .vec_read(vec_read), .vec_addr(vec_addr), .vec_data(vec_data),
        .pc_out(pc_out), .p_out(p_out), .a_out(a_out),
        .pc_load(pc_load), .p_load(p_load), .a_load(a_load),
        .done(done), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          pops_exp = 0;
    int          stall_cfg = 0;
    bit          outstanding = 0;
    bit          mon_en = 0;
    logic        prev_strb = 1'b0;
    logic [7:0]  push_q[$];
    logic [15:0] vaddr_q[$];
    logic [7:0]  popd_q[$];
    logic [7:0]  vecd_q[$];
    done_t       done_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory model: supplies popped/vector bytes and stalls mem_ready.
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b1;
        stack_data_in = 8'h00;
        vec_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                cnt = 0;
                mem_ready = 1'b1;
            end else if (stack_push || stack_pop || vec_read) begin
                if (stack_pop && popd_q.size() > 0)
                    stack_data_in = popd_q.pop_front();
                if (vec_read && vecd_q.size() > 0)
                    vec_data = vecd_q.pop_front();
                cnt = stall_cfg;
                mem_ready = (cnt == 0);
            end else if (cnt > 0) begin
                cnt--;
                mem_ready = (cnt == 0);
            end
        end
    end

    // Monitor: compares every strobe and completion with the scoreboard.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (stack_push || stack_pop || vec_read) begin
                chk("one_strobe",
                    32'(stack_push) + 32'(stack_pop) + 32'(vec_read), 1);
                chk("strobe_single_cycle", prev_strb, 0);
            end
            if (stack_push) begin
                chk("push_expected", push_q.size() > 0, 1);
                if (push_q.size() > 0)
                    chk("push_data", stack_data_out, push_q.pop_front());
            end
            if (stack_pop) begin
                chk("pop_expected", pops_exp > 0, 1);
                if (pops_exp > 0) pops_exp--;
            end
            if (vec_read) begin
                chk("vec_expected", vaddr_q.size() > 0, 1);
                if (vaddr_q.size() > 0)
                    chk("vec_addr", vec_addr, vaddr_q.pop_front());
            end
            if (outstanding) chk("busy", busy, 1);
            if (done) begin
                chk("done_expected", done_q.size() > 0, 1);
                if (done_q.size() > 0) begin
                    done_t e;
                    e = done_q.pop_front();
                    if (e.lat != 0)
                        chk("latency", cyc + 1 - accept_cyc, e.lat);
                    chk("loads", {pc_load, p_load, a_load},
                        {e.pcl, e.pl, e.al});
                    if (e.pcl) chk("pc_out", pc_out, e.pc);
                    if (e.pl)  chk("p_out", p_out, e.p);
                    if (e.al)  chk("a_out", a_out, e.a);
                end
                outstanding = 0;
            end
        end
        prev_strb = (rst_n === 1'b1) && (stack_push || stack_pop || vec_read);
    end

    task automatic exp_done(input int lat, input logic pcl, input logic pl,
                            input logic al, input logic [15:0] pc,
                            input logic [7:0] p, input logic [7:0] a);
        done_t e;
        e = '{lat, pcl, pl, al, pc, p, a};
        done_q.push_back(e);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [1:0] vec,
                          input logic brk, input logic [15:0] pc,
                          input logic [7:0] p, input logic [7:0] a,
                          input bit poke, input bit wait_done);
        int n;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_vec = vec;
        cmd_brk = brk;
        pc_in = pc;
        p_in = p;
        a_in = a;
        accept_cyc = cyc + 1;
        @(negedge clk);
        outstanding = 1;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        pc_in = 16'h0000;
        p_in = 8'h00;
        a_in = 8'h00;
        if (poke) begin
            repeat (2) begin
                @(negedge clk);
                cmd_valid = 1'b1;
                cmd_op = 3'd0;
                a_in = 8'hEE;
            end
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        if (wait_done) begin
            n = 0;
            while (outstanding && n < 300) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (outstanding) begin
                chk("done_timeout", outstanding, 0);
                outstanding = 0;
            end
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        cmd_vec = 2'd0;
        cmd_brk = 1'b0;
        pc_in = 16'h0;
        p_in = 8'h0;
        a_in = 8'h0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {stack_push, stack_pop, vec_read}, 0);
        chk("rst_pulses", {done, pc_load, p_load, a_load}, 0);
        chk("rst_pc_out", pc_out, 16'h0000);
        chk("rst_p_out", p_out, 8'h20);
        chk("rst_a_out", a_out, 8'h00);
        chk("rst_data_out", stack_data_out, 8'h00);
        chk("rst_vec_addr", vec_addr, 16'h0000);
        rst_n = 1'b1;
        mon_en = 1;

        push_q.push_back(8'h5A);
        exp_done(3, 0, 0, 0, 16'h0, 8'h0, 8'h0);
        do_cmd(3'd0, 2'd0, 1'b0, 16'h0, 8'h00, 8'h5A, 0, 1);

        push_q.push_back(8'h31);
        exp_done(3, 0, 0, 0, 16'h0, 8'h0, 8'h0);
        do_cmd(3'd1, 2'd0, 1'b0, 16'h0, 8'h01, 8'h00, 0, 1);

        push_q.push_back(8'h12);
        push_q.push_back(8'h34);
        exp_done(5, 0, 0, 0, 16'h0, 8'h0, 8'h0);
        do_cmd(3'd4, 2'd0, 1'b0, 16'h1234, 8'h00, 8'h00, 0, 1);

        pops_exp = 2;
        popd_q.push_back(8'hFF);
        popd_q.push_back(8'hFF);
        exp_done(5, 1, 0, 0, 16'h0000, 8'h0, 8'h0);
        do_cmd(3'd5, 2'd0, 1'b0, 16'h0, 8'h00, 8'h00, 0, 1);

        pops_exp = 1;
        popd_q.push_back(8'h80);
        exp_done(3, 0, 0, 1, 16'h0, 8'h0, 8'h80);
        do_cmd(3'd2, 2'd0, 1'b0, 16'h0, 8'h00, 8'h00, 0, 1);

        pops_exp = 1;
        popd_q.push_back(8'hFF);
        exp_done(3, 0, 1, 0, 16'h0, 8'hEF, 8'h0);
        do_cmd(3'd3, 2'd0, 1'b0, 16'h0, 8'h00, 8'h00, 0, 1);

        push_q.push_back(8'hC0);
        push_q.push_back(8'h00);
        push_q.push_back(8'h31);
        vaddr_q.push_back(16'hFFFE);
        vaddr_q.push_back(16'hFFFF);
        vecd_q.push_back(8'h00);
        vecd_q.push_back(8'h80);
        exp_done(11, 1, 1, 0, 16'h8000, 8'h05, 8'h0);
        do_cmd(3'd6, 2'd2, 1'b1, 16'hC000, 8'h01, 8'h00, 0, 1);

        push_q.push_back(8'hAB);
        push_q.push_back(8'hCD);
        push_q.push_back(8'hE4);
        vaddr_q.push_back(16'hFFFA);
        vaddr_q.push_back(16'hFFFB);
        vecd_q.push_back(8'h34);
        vecd_q.push_back(8'h12);
        exp_done(11, 1, 1, 0, 16'h1234, 8'hC4, 8'h0);
        do_cmd(3'd6, 2'd0, 1'b0, 16'hABCD, 8'hC4, 8'h00, 0, 1);

        stall_cfg = 4;
        pops_exp = 3;
        popd_q.push_back(8'hFF);
        popd_q.push_back(8'h10);
        popd_q.push_back(8'h20);
        exp_done(0, 1, 1, 0, 16'h2010, 8'hEF, 8'h0);
        do_cmd(3'd7, 2'd0, 1'b0, 16'h0, 8'h00, 8'h00, 1, 1);
        stall_cfg = 0;

        stall_cfg = 20;
        push_q.push_back(8'h12);
        push_q.push_back(8'h34);
        do_cmd(3'd4, 2'd0, 1'b0, 16'h1234, 8'h00, 8'h00, 0, 0);
        n = 0;
        while (push_q.size() > 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("jsr_second_push_seen", push_q.size(), 0);
        @(negedge clk);
        chk("jsr_wait_busy", busy, 1);
        rst_n = 1'b0;
        outstanding = 0;
        stall_cfg = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);
        repeat (10) @(negedge clk);

        chk("push_q_drained", push_q.size(), 0);
        chk("vaddr_q_drained", vaddr_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        chk("pops_drained", pops_exp, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Upstream driver of the memory controller's stack port.
- Turns one decoded stack-class instruction (PHA, PHP, PLA, PLP, JSR, RTS, interrupt entry, RTI) into an ordered sequence of single-byte stack push/pop strobes.
- Fetches the interrupt vector over a separate read port and returns the reconstructed PC/P/A to the core with one-cycle load pulses.

Parameters:
- NMI_VEC, 16'hFFFA, vector address for cmd_vec=2'd0
- RST_VEC, 16'hFFFC, vector address for cmd_vec=2'd1
- IRQ_VEC, 16'hFFFE, vector address for cmd_vec=2'd2/2'd3 (IRQ and BRK)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in IDLE; a command is accepted on valid&&ready
- cmd_op  input  3  0 PHA, 1 PHP, 2 PLA, 3 PLP, 4 JSR, 5 RTS, 6 INT, 7 RTI
- cmd_vec  input  2  vector select for INT
- cmd_brk  input  1  INT caused by BRK (sets B in pushed P)
- pc_in  input  16  PC to push; sampled at accept
- p_in  input  8  status to push; sampled at accept
- a_in  input  8  accumulator to push; sampled at accept
- stack_push  output  1  one-cycle push strobe to memory controller
- stack_pop  output  1  one-cycle pop strobe to memory controller
- stack_data_out  output  8  byte being pushed; valid while stack_push=1
- stack_data_in  input  8  popped byte from memory controller
- mem_ready  input  1  memory controller ready (cpu_ready)
- vec_read  output  1  one-cycle vector byte read strobe
- vec_addr  output  16  vector byte address; valid while vec_read=1
- vec_data  input  8  vector byte, captured when mem_ready=1 in VWAIT
- pc_out  output  16  result PC (RTS/RTI/INT)
- p_out  output  8  result status (PLP/RTI/INT)
- a_out  output  8  result accumulator (PLA)
- pc_load / p_load / a_load  output  1 each  one-cycle load pulses, asserted with done
- done  output  1  one-cycle completion pulse
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset values (rst_n=0 at an edge):
  - state=IDLE
  - all strobes, load pulses, done and busy = 0
  - pc_out=16'h0000, p_out=8'h20, a_out=8'h00
  - stack_data_out=8'h00, vec_addr=16'h0000
- Reset mid-sequence aborts at the next edge: no further strobes, no done.
- States: IDLE, REQ, WAIT, VREQ, VWAIT, DONE. A 2-bit byte index idx counts 0..n-1.
- IDLE:
  - cmd_ready=1.
  - On accept: latch op/vec/brk/pc/p/a, idx=0, go to REQ.
- REQ:
  - Assert exactly one of stack_push or stack_pop for one cycle, then go to WAIT.
- WAIT:
  - Hold until mem_ready=1.
  - For a pop, capture stack_data_in into the byte slot for idx.
  - If more bytes remain: idx++, go to REQ. Otherwise go to VREQ (INT) or DONE.
- VREQ/VWAIT: two reads, vec then vec+1; low byte to pc_out[7:0], high byte to pc_out[15:8]. Same strobe/wait rule as REQ/WAIT.
- DONE:
  - done=1 for one cycle, with the relevant load pulses.
  - Return to IDLE; the next command can be accepted in the following cycle.
- Byte orders:
  - PHA: push a
  - PHP: push p|8'h30
  - JSR: push pc[15:8], then pc[7:0]
  - INT: push pc[15:8], pc[7:0], then {p[7:6],1,cmd_brk,p[3:0]}
  - RTS: pop PCL, PCH
  - RTI: pop P, PCL, PCH
- Result rules:
  - Popped P is written as {b[7:6],1'b1,1'b0,b[3:0]} (PLP, RTI).
  - RTS: pc_out = {PCH,PCL}+1, 16-bit wrap (16'hFFFF -> 16'h0000).
  - INT: p_out = p_in | 8'h04 (I set), with pc_load and p_load.
  - JSR: done only; no loads.
- Latency with mem_ready tied 1: accept at T0, then 2 cycles per byte, then DONE.
  - PHA: done at T3
  - JSR/RTS: done at T5
  - RTI: done at T7
  - INT: done at T11
- Invariants:
  - Never assert stack_push and stack_pop together.
  - Never assert a stack strobe and vec_read together.
  - Never issue more than one strobe per byte.
- mem_ready stuck low stalls indefinitely in WAIT/VWAIT, with busy=1. There is no timeout.
- cmd_valid while busy is ignored; the command is not queued.

Decomposition:
- Package stack_seq_pkg holds:
  - op enum (PHA..RTI)
  - state enum
  - vector-select encodings
  - status bit-index constants (I=2, B=4, U=5)
- No sub-module; the block is a single FSM plus datapath registers.

Test Plan:
- mem_ready=1, PHA with a_in=8'h5A -> one push with stack_data_out=8'h5A; done at T3; no loads.
- JSR with pc_in=16'h1234 -> pushes 8'h12 then 8'h34; exactly 2 push strobes; done at T5; pc_load=0.
- RTS with pops 8'hFF, 8'hFF -> pc_out=16'h0000 (wrap); pc_load=1 with done.
- INT, cmd_vec=2, cmd_brk=1, pc=16'hC000, p=8'h01, vec bytes 8'h00, 8'h80:
  - pushes C0, 00, 31
  - vec_addr FFFE then FFFF
  - pc_out=16'h8000, p_out=8'h05
- RTI with pops 8'hFF, 8'h10, 8'h20 and mem_ready low for 3 cycles per byte:
  - p_out=8'hEF, pc_out=16'h2010
  - strobes stay single-cycle; busy held throughout.
- rst_n=0 in the WAIT of the second JSR byte -> no further strobes, no done; cmd_ready=1 the cycle after rst_n returns high.
